// File: rtl/jamma_input_conditioner.sv
// ---------------------------------------------------------------------------
// jamma_input_conditioner
//
// Conditions CH raw JAMMA edge inputs (buttons, coin, service, tilt) before
// they reach the CPU register / IRQ logic. Each channel goes through:
//   2-FF synchroniser -> ena-paced debouncer -> mode-qualified edge pulse
//   -> sticky event flag and wrapping edge counter.
//
// Ports
//   clk      system clock
//   clrn     asynchronous reset, active low
//   ena      debounce sample strobe (one clk wide)
//   in       raw asynchronous pin inputs, one bit per channel
//   mode     per channel [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
//   ack      per-channel clear strobe for the sticky event flag
//   cnt_sel  channel whose counter appears on cnt_q and is hit by cnt_clr
//   cnt_clr  clear the counter of channel cnt_sel
//   level    debounced level per channel (registered)
//   pulse    one-clk pulse on each accepted, mode-enabled edge (registered)
//   evt      sticky event flags (registered)
//   irq      OR of all event flags
//   cnt_q    counter of channel cnt_sel, zero when cnt_sel >= CH
// ---------------------------------------------------------------------------
module jamma_input_conditioner #(
  parameter int CH         = 8,
  parameter int DEB_LEN    = 4,
  parameter int CNT_W      = 8,
  parameter bit INIT_LEVEL = 1'b1
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              ena,
  input  logic [CH-1:0]     in,
  input  logic [2*CH-1:0]   mode,
  input  logic [CH-1:0]     ack,
  input  logic [3:0]        cnt_sel,
  input  logic              cnt_clr,
  output logic [CH-1:0]     level,
  output logic [CH-1:0]     pulse,
  output logic [CH-1:0]     evt,
  output logic              irq,
  output logic [CNT_W-1:0]  cnt_q
);

  // A run counter of at least one bit keeps DEB_LEN=1 legal.
  localparam int                DCNT_W    = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEB_LEN - 1);

  logic [CH-1:0]     sync_p0;
  logic [CH-1:0]     sync_p1;
  logic [DCNT_W-1:0] dcnt [CH];
  logic [CNT_W-1:0]  cnt  [CH];

  // An accepted change to new_lvl produces a pulse when the matching mode
  // bit is set: bit0 qualifies rising edges, bit1 falling edges.
  function automatic logic edge_hit(input logic new_lvl, input logic [1:0] m);
    return new_lvl ? m[0] : m[1];
  endfunction

  // Stage p0/p1: two-flop synchroniser, runs every clk regardless of ena.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      sync_p0 <= {CH{INIT_LEVEL}};
      sync_p1 <= {CH{INIT_LEVEL}};
    end else begin
      sync_p0 <= in;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce stage: a new level is accepted only after DEB_LEN consecutive
  // ena ticks disagree with the current level. The pulse is registered on
  // the same edge as the level so both appear in the same cycle.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      level <= {CH{INIT_LEVEL}};
      pulse <= '0;
      for (int i = 0; i < CH; i++) begin
        dcnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        pulse[i] <= 1'b0;
        if (ena) begin
          if (sync_p1[i] == level[i]) begin
            dcnt[i] <= '0;
          end else if (dcnt[i] == DCNT_LAST) begin
            level[i] <= sync_p1[i];
            dcnt[i]  <= '0;
            pulse[i] <= edge_hit(sync_p1[i], mode[2*i +: 2]);
          end else begin
            dcnt[i] <= dcnt[i] + DCNT_W'(1);
          end
        end
      end
    end
  end

  // Event / counter stage: both follow pulse by one clk. A set coinciding
  // with ack keeps the flag; a clear coinciding with an increment leaves 1
  // so that edge is not lost.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      evt <= '0;
      for (int i = 0; i < CH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        evt[i] <= pulse[i] | (evt[i] & ~ack[i]);
        if (cnt_clr && (cnt_sel == 4'(i))) begin
          cnt[i] <= pulse[i] ? CNT_W'(1) : '0;
        end else if (pulse[i]) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign irq = |evt;

  // Out-of-range selects fall through to zero.
  always_comb begin
    cnt_q = '0;
    for (int i = 0; i < CH; i++) begin
      if (cnt_sel == 4'(i)) begin
        cnt_q = cnt[i];
      end
    end
  end

endmodule

// File: tb/tb_jamma_input_conditioner.sv
module tb_jamma_input_conditioner;

  localparam int CH  = 8;
  localparam int DEB = 4;
  localparam int CW  = 8;

  logic            clk = 1'b0;
  logic            clrn;
  logic            ena;
  logic [CH-1:0]   in;
  logic [2*CH-1:0] mode;
  logic [CH-1:0]   ack;
  logic [3:0]      cnt_sel;
  logic            cnt_clr;
  logic [CH-1:0]   level;
  logic [CH-1:0]   pulse;
  logic [CH-1:0]   evt;
  logic            irq;
  logic [CW-1:0]   cnt_q;

  int n_cmp = 0;
  int n_bad = 0;
  bit done  = 1'b0;

  jamma_input_conditioner #(
    .CH(CH), .DEB_LEN(DEB), .CNT_W(CW), .INIT_LEVEL(1'b1)
  ) dut (
    .clk(clk), .clrn(clrn), .ena(ena), .in(in), .mode(mode), .ack(ack),
    .cnt_sel(cnt_sel), .cnt_clr(cnt_clr), .level(level), .pulse(pulse),
    .evt(evt), .irq(irq), .cnt_q(cnt_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  // The synchroniser is a 2-sample delay of in. The debouncer is expressed
  // as "ticks elapsed since the level last agreed": once DEB ticks in a row
  // have disagreed the new level is taken.
  logic [CH-1:0] m_d1, m_d2, m_level, m_pulse, m_evt, p_old, p_new;
  int m_cnt  [CH];
  int m_tick [CH];
  int m_ok   [CH];

  always @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      m_d1 = '1; m_d2 = '1; m_level = '1; m_pulse = '0; m_evt = '0;
      for (int ch = 0; ch < CH; ch++) begin
        m_cnt[ch] = 0; m_tick[ch] = 0; m_ok[ch] = 0;
      end
    end else begin
      p_old = m_pulse;
      p_new = '0;
      for (int ch = 0; ch < CH; ch++) begin
        if (ena) begin
          m_tick[ch]++;
          if (m_d2[ch] == m_level[ch]) begin
            m_ok[ch] = m_tick[ch];
          end else if (m_tick[ch] - m_ok[ch] >= DEB) begin
            m_level[ch] = m_d2[ch];
            m_ok[ch]    = m_tick[ch];
            p_new[ch]   = m_d2[ch] ? mode[2*ch] : mode[2*ch+1];
          end
        end
        m_evt[ch] = p_old[ch] | (m_evt[ch] & ~ack[ch]);
        if (cnt_clr && int'(cnt_sel) == ch)
          m_cnt[ch] = p_old[ch] ? 1 : 0;
        else if (p_old[ch])
          m_cnt[ch] = (m_cnt[ch] + 1) % (1 << CW);
      end
      m_pulse = p_new;
      m_d2 = m_d1;
      m_d1 = in;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!done) begin
      chk("level", 32'(level), 32'(m_level));
      chk("pulse", 32'(pulse), 32'(m_pulse));
      chk("evt",   32'(evt),   32'(m_evt));
      chk("irq",   32'(irq),   32'(|m_evt));
      chk("cnt_q", 32'(cnt_q), (int'(cnt_sel) < CH) ? 32'(m_cnt[cnt_sel]) : 32'd0);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clrn = 1'b0; ena = 1'b1; in = '1; ack = '0; cnt_sel = '0; cnt_clr = 1'b0;
    mode = 16'hFFFF;
    mode[1:0] = 2'b10;   // ch0 fall only
    mode[7:6] = 2'b01;   // ch3 rise only
    mode[9:8] = 2'b01;   // ch4 rise only
    step(3);
    chk("reset_level", 32'(level), 32'hFF);
    chk("reset_pulse", 32'(pulse), 32'h0);
    chk("reset_evt",   32'(evt),   32'h0);
    chk("reset_cnt",   32'(cnt_q), 32'h0);
    clrn = 1'b1;
    step(4);

    // Test 1: latency 2+4 clk, mode qualification on ch0.
    in[0] = 1'b0;
    step(5);
    chk("t1_level_before", 32'(level[0]), 32'd1);
    step(1);
    chk("t1_level_after", 32'(level[0]), 32'd0);
    chk("t1_pulse_fall10", 32'(pulse[0]), 32'd1);
    step(1);
    chk("t1_pulse_oneclk", 32'(pulse[0]), 32'd0);
    chk("t1_evt", 32'(evt[0]), 32'd1);
    mode[1:0] = 2'b00; in[0] = 1'b1; step(6);
    chk("t1_pulse_rise00", 32'(pulse[0]), 32'd0);
    step(1);
    mode[1:0] = 2'b01; in[0] = 1'b0; step(6);
    chk("t1_pulse_fall01", 32'(pulse[0]), 32'd0);
    step(1);
    mode[1:0] = 2'b11; in[0] = 1'b1; step(6);
    chk("t1_pulse_rise11", 32'(pulse[0]), 32'd1);
    step(2);

    // Test 2: 3-tick glitch on ch1 is rejected.
    in[1] = 1'b0; step(3); in[1] = 1'b1; step(10);
    cnt_sel = 4'd1; #1;
    chk("t2_level", 32'(level[1]), 32'd1);
    chk("t2_evt",   32'(evt[1]),   32'd0);
    chk("t2_cnt",   32'(cnt_q),    32'd0);

    // Test 3: three toggles on ch2 in both-edge mode.
    ack = '1; step(1); ack = '0;
    in[2] = 1'b0; step(7); in[2] = 1'b1; step(7); in[2] = 1'b0; step(7);
    cnt_sel = 4'd2; #1;
    chk("t3_cnt",  32'(cnt_q),  32'd3);
    chk("t3_evt",  32'(evt[2]), 32'd1);
    chk("t3_irq",  32'(irq),    32'd1);
    ack[2] = 1'b1; step(1); ack[2] = 1'b0;
    chk("t3_evt_ack", 32'(evt[2]), 32'd0);
    chk("t3_irq_ack", 32'(irq),    32'd0);

    // Test 4: set-wins over ack, increment-wins over clear on ch3.
    in[3] = 1'b0; step(7); in[3] = 1'b1; step(7); in[3] = 1'b0; step(7);
    ack[3] = 1'b1; step(1); ack[3] = 1'b0;
    in[3] = 1'b1; step(6);
    chk("t4_pulse", 32'(pulse[3]), 32'd1);
    ack[3] = 1'b1; cnt_sel = 4'd3; cnt_clr = 1'b1;
    step(1);
    ack[3] = 1'b0; cnt_clr = 1'b0; #1;
    chk("t4_evt_setwins", 32'(evt[3]), 32'd1);
    chk("t4_cnt_clr_inc", 32'(cnt_q),  32'd1);
    step(1);
    chk("t4_evt_hold", 32'(evt[3]), 32'd1);

    // Test 5: 256 rising edges on ch4 wrap the counter.
    cnt_sel = 4'd4;
    for (int k = 0; k < 256; k++) begin
      in[4] = 1'b0; step(7); in[4] = 1'b1; step(7);
      if (k == 254) chk("t5_cnt_255", 32'(cnt_q), 32'd255);
    end
    chk("t5_cnt_wrap", 32'(cnt_q), 32'd0);
    cnt_sel = 4'd8;  #1; chk("t5_sel8",  32'(cnt_q), 32'd0);
    cnt_sel = 4'd10; #1; chk("t5_sel10", 32'(cnt_q), 32'd0);
    cnt_sel = 4'd3;  step(1);

    // Test 6: slow ena, reset mid-debounce on ch5.
    in[5] = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      ena = (c % 10 == 0); step(1);
    end
    ena = 1'b0;
    #2 clrn = 1'b0;
    #1;
    chk("t6_rst_level", 32'(level), 32'hFF);
    chk("t6_rst_pulse", 32'(pulse), 32'h0);
    chk("t6_rst_evt",   32'(evt),   32'h0);
    chk("t6_rst_irq",   32'(irq),   32'h0);
    chk("t6_rst_cnt",   32'(cnt_q), 32'h0);
    step(2);
    clrn = 1'b1;
    for (int c = 1; c <= 45; c++) begin
      ena = (c % 10 == 0); step(1);
      if (c == 39) chk("t6_level_3ticks", 32'(level[5]), 32'd1);
      if (c == 40) begin
        chk("t6_level_4ticks", 32'(level[5]), 32'd0);
        chk("t6_pulse_4ticks", 32'(pulse[5]), 32'd1);
      end
    end
    ena = 1'b1;

    // Randomised traffic, checked every cycle by the model.
    for (int c = 0; c < 3000; c++) begin
      ena = ($urandom_range(0, 2) == 0);
      for (int ch = 0; ch < CH; ch++)
        if ($urandom_range(0, 3 + ch * 6) == 0) in[ch] = ~in[ch];
      if ($urandom_range(0, 63) == 0) mode = 16'($urandom);
      ack     = 8'($urandom) & 8'($urandom) & 8'($urandom);
      cnt_sel = 4'($urandom);
      cnt_clr = ($urandom_range(0, 15) == 0);
      step(1);
    end

    @(negedge clk);
    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
